// File: rtl/dm_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter:
//     owner_t       - which master owns a beat (CPU = 0, DMA = 1)
//     ret_t         - registered record of the beat whose response returns
//                     on the next cycle (read flag, range error, owner)
//     *_DEF         - default sizes used by the top-level parameters
//     BYTEEN_W      - byte-enable width of a 32-bit memory word
//     other_owner() - the master that is not the given one
// -----------------------------------------------------------------------------
package dm_port_arbiter_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W          = 32;
    localparam int BYTEEN_W        = DATA_W / 8;
    localparam int DEPTH_WORDS_DEF = 4096;
    localparam int MAX_BURST_DEF   = 4;

    // Response-side record of the previous cycle's beat.
    typedef struct packed {
        logic   rd;     // beat was a read (byteen == 0)
        logic   oor;    // beat address was out of range
        owner_t owner;  // master that owned the beat
    } ret_t;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//   Two-way round-robin arbiter with a burst limit. A master that owned the
//   previous cycle's beat may keep the grant while its run of consecutive
//   beats is below MAX_BURST; otherwise a tie goes to the master that did not
//   own the most recent beat. A lone requester is always granted.
//
//   Ports:
//     clk            clock
//     reset          synchronous, active-low reset
//     req[1:0]       request per master (bit 0 = CPU, bit 1 = DMA)
//     gnt[1:0]       one-hot grant, combinational from req and state;
//                    forced to 0 while reset is asserted
//     last_owner     owner of the most recent beat (OWN_DMA after reset so the
//                    CPU wins the first tie)
//     burst_cnt      length of the current run of beats; 0 after a cycle
//                    with no beat
//
//   Handshake: a beat happens on a cycle where req[i] & gnt[i]; the requester
//   holds req until it sees gnt, and gnt is never raised without req.
// -----------------------------------------------------------------------------
module rr_burst_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output owner_t           last_owner,
    output logic [CNT_W-1:0] burst_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    owner_t           last_owner_q;
    logic [CNT_W-1:0] burst_cnt_q;
    owner_t           win;
    logic             any_req;
    logic             keep_ok;
    logic             beat;

    always_comb begin
        win     = last_owner_q;
        any_req = 1'b0;
        // A non-zero count means last_owner_q owned last cycle's beat.
        keep_ok = (burst_cnt_q != '0) && (burst_cnt_q < MAX_CNT);
        case (req)
            2'b01: begin
                win     = OWN_CPU;
                any_req = 1'b1;
            end
            2'b10: begin
                win     = OWN_DMA;
                any_req = 1'b1;
            end
            2'b11: begin
                win     = keep_ok ? last_owner_q : other_owner(last_owner_q);
                any_req = 1'b1;
            end
            default: begin
                win     = last_owner_q;
                any_req = 1'b0;
            end
        endcase
        // No beat may be accepted in a reset cycle.
        beat = any_req && reset;
        gnt  = 2'b00;
        if (beat) begin
            gnt = (win == OWN_DMA) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_owner_q <= OWN_DMA;
            burst_cnt_q  <= '0;
        end else if (beat) begin
            if ((burst_cnt_q != '0) && (win == last_owner_q)) begin
                // Saturate: a lone requester can run past MAX_BURST, and the
                // count only has to show "limit reached" once a rival appears.
                if (burst_cnt_q != MAX_CNT) begin
                    burst_cnt_q <= burst_cnt_q + ONE_CNT;
                end
            end else begin
                burst_cnt_q <= ONE_CNT;
            end
            last_owner_q <= win;
        end else begin
            burst_cnt_q <= '0;
        end
    end

    assign last_owner = last_owner_q;
    assign burst_cnt  = burst_cnt_q;

endmodule

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//   Shares a single-port, word-addressed data memory (byte-enabled writes,
//   1-cycle read latency) between the CPU M-stage data port (master 0) and a
//   DMA/peripheral engine (master 1). Round-robin arbitration with a burst
//   limit is done in rr_burst_arbiter; this level muxes the granted master
//   onto the memory port, range-checks the address and returns read data.
//
//   Ports:
//     clk, reset                    clock, synchronous active-low reset
//     mN_req/addr/wdata/byteen      request from master N (byteen 0 = read)
//     mN_gnt                        beat accepted this cycle (combinational)
//     mN_rvalid                     read data for master N valid this cycle
//     mN_err                        previous beat of master N was out of range
//     rdata                         shared read data, qualified by mN_rvalid
//     mem_addr/mem_wdata/mem_byteen memory request (byteen 0 = no write)
//     mem_rdata                     memory read data, 1 cycle after mem_addr
//
//   Handshake: master N holds mN_req with stable addr/wdata/byteen until it
//   sees mN_gnt; the cycle with mN_req & mN_gnt is the beat. Each beat is
//   answered exactly one cycle later: mN_rvalid for reads, mN_err for any
//   out-of-range beat. There is no back-pressure on the response side.
// -----------------------------------------------------------------------------
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int MAX_BURST   = MAX_BURST_DEF
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [BYTEEN_W-1:0] m0_byteen,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic                m0_err,

    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [BYTEEN_W-1:0] m1_byteen,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic                m1_err,

    output logic [DATA_W-1:0]   rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [BYTEEN_W-1:0] mem_byteen,
    input  logic [DATA_W-1:0]   mem_rdata
);

    // First illegal byte address, one bit wider so DEPTH_WORDS*4 == 2**ADDR_W
    // still fits.
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS) << 2;
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~(ADDR_W'(3));

    logic [1:0]          gnt;
    logic                beat;
    logic                sel_dma;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BYTEEN_W-1:0] sel_byteen;
    logic                in_range;
    owner_t              arb_last_owner;
    logic [$clog2(MAX_BURST + 1)-1:0] arb_burst_cnt;
    ret_t                ret_q;

    rr_burst_arbiter #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        ({m1_req, m0_req}),
        .gnt        (gnt),
        .last_owner (arb_last_owner),
        .burst_cnt  (arb_burst_cnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Request mux and range check for the granted master.
    always_comb begin
        beat       = |gnt;
        sel_dma    = gnt[1];
        sel_addr   = sel_dma ? m1_addr   : m0_addr;
        sel_wdata  = sel_dma ? m1_wdata  : m0_wdata;
        sel_byteen = sel_dma ? m1_byteen : m0_byteen;
        in_range   = {1'b0, sel_addr} < ADDR_LIMIT;

        mem_addr   = '0;
        mem_wdata  = '0;
        mem_byteen = '0;
        if (beat) begin
            mem_addr  = sel_addr & WORD_MASK;
            mem_wdata = sel_wdata;
            // An out-of-range beat is still accepted but must not write.
            if (in_range) begin
                mem_byteen = sel_byteen;
            end
        end
    end

    // One-cycle response pipeline, aligned with the memory's read latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ret_q.rd    <= 1'b0;
            ret_q.oor   <= 1'b0;
            ret_q.owner <= OWN_CPU;
        end else begin
            ret_q.rd    <= beat && (sel_byteen == '0);
            ret_q.oor   <= beat && !in_range;
            ret_q.owner <= sel_dma ? OWN_DMA : OWN_CPU;
        end
    end

    // Responses are qualified by reset so that a beat accepted just before a
    // reset cycle never returns during that reset cycle.
    always_comb begin
        m0_rvalid = reset && ret_q.rd  && (ret_q.owner == OWN_CPU);
        m1_rvalid = reset && ret_q.rd  && (ret_q.owner == OWN_DMA);
        m0_err    = reset && ret_q.oor && (ret_q.owner == OWN_CPU);
        m1_err    = reset && ret_q.oor && (ret_q.owner == OWN_DMA);
        rdata     = '0;
        if (reset && ret_q.rd && !ret_q.oor) begin
            rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
//   Directed bench for dm_port_arbiter. A small behavioural memory answers the
//   DUT's memory port. A reference model (run length / last owner / pending
//   response, plus a golden copy of memory) predicts every output each cycle;
//   a few literal expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;
    import dm_port_arbiter_pkg::*;

    localparam int DEPTH = 4096;
    localparam int MAXB  = 4;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;

    dm_port_arbiter #(
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH),
        .MAX_BURST   (MAXB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_byteen  (m0_byteen),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_err     (m0_err),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_byteen  (m1_byteen),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_err     (m1_err),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [31:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE0000 + 32'(i);
        forever begin
            @(posedge clk);
            mem_rdata <= mem[mem_addr[13:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_byteen[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [31:0] gold [0:DEPTH-1];
    initial begin : model
        int prev_own, last_own, run, w;
        logic pend_rd, pend_oor;
        int pend_own;
        logic [31:0] pend_data, a, wd;
        logic [3:0] be;
        logic oor, ev0, ev1;
        prev_own = -1; last_own = 1; run = 0;
        pend_rd = 1'b0; pend_oor = 1'b0; pend_own = 0; pend_data = '0;
        for (int i = 0; i < DEPTH; i++) gold[i] = 32'hC0DE0000 + 32'(i);
        forever begin
            @(negedge clk);
            w = -1;
            if (reset) begin
                if (m0_req && !m1_req) w = 0;
                else if (m1_req && !m0_req) w = 1;
                else if (m0_req && m1_req)
                    w = (prev_own >= 0 && run < MAXB) ? prev_own : 1 - last_own;
            end
            a   = (w == 1) ? m1_addr   : m0_addr;
            wd  = (w == 1) ? m1_wdata  : m0_wdata;
            be  = (w == 1) ? m1_byteen : m0_byteen;
            oor = (a >= LIMIT);
            chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
            chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
            chk("mem_byteen", 32'(mem_byteen), (w >= 0 && !oor) ? 32'(be) : 32'd0);
            chk("mem_addr", mem_addr, (w >= 0) ? {a[31:2], 2'b00} : 32'd0);
            if (w >= 0) chk("mem_wdata", mem_wdata, wd);
            ev0 = reset && pend_rd && pend_own == 0;
            ev1 = reset && pend_rd && pend_own == 1;
            chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
            chk("m0_err", 32'(m0_err), 32'(reset && pend_oor && pend_own == 0));
            chk("m1_err", 32'(m1_err), 32'(reset && pend_oor && pend_own == 1));
            if (ev0 || ev1) chk("rdata", rdata, pend_oor ? 32'd0 : pend_data);
            // advance to the next cycle
            if (!reset) begin
                prev_own = -1; last_own = 1; run = 0;
                pend_rd = 1'b0; pend_oor = 1'b0;
            end else begin
                pend_rd   = (w >= 0) && (be == 4'd0);
                pend_oor  = (w >= 0) && oor;
                pend_own  = w;
                pend_data = gold[a[13:2]];
                if (w >= 0 && !oor) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) gold[a[13:2]][8*b +: 8] = wd[8*b +: 8];
                end
                if (w >= 0) begin
                    run = (w == prev_own) ? run + 1 : 1;
                    prev_own = w;
                    last_own = w;
                end else begin
                    run = 0;
                    prev_own = -1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        m0_req = r; m0_addr = a; m0_wdata = d; m0_byteen = be;
    endtask

    task automatic drive_m1(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        m1_req = r; m1_addr = a; m1_wdata = d; m1_byteen = be;
    endtask

    // ---------------- directed sequence ----------------
    int gseq[$];
    int exp_order [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        reset = 1'b0;
        drive_m0(1'b0, '0, '0, '0);
        drive_m1(1'b0, '0, '0, '0);
        repeat (3) step();
        look();
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_mem_byteen", 32'(mem_byteen), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        step(); reset = 1'b1;
        step();

        // lone CPU read of word 4
        drive_m0(1'b1, 32'h10, '0, 4'b0000);
        look();
        chk("rd10_gnt", 32'(m0_gnt), 32'd1);
        chk("rd10_mem_addr", mem_addr, 32'h10);
        step(); drive_m0(1'b0, '0, '0, '0);
        look();
        chk("rd10_rvalid", 32'(m0_rvalid), 32'd1);
        chk("rd10_rdata", rdata, 32'hC0DE0004);
        chk("rd10_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // lone DMA partial write to 0x20
        step(); drive_m1(1'b1, 32'h20, 32'hDEADBEEF, 4'b0011);
        look();
        chk("wr20_byteen", 32'(mem_byteen), 32'h3);
        chk("wr20_mem_addr", mem_addr, 32'h20);
        step(); drive_m1(1'b0, '0, '0, '0);
        look();
        chk("wr20_no_rvalid", 32'(m1_rvalid), 32'd0);

        // last legal word, then first illegal address
        step(); drive_m0(1'b1, 32'h3FFC, 32'h12345678, 4'b1111);
        look();
        chk("wr3ffc_byteen", 32'(mem_byteen), 32'hF);
        step(); drive_m0(1'b1, 32'h4000, 32'hCAFEF00D, 4'b1111);
        look();
        chk("wr4000_gnt", 32'(m0_gnt), 32'd1);
        chk("wr4000_byteen", 32'(mem_byteen), 32'h0);
        chk("wr3ffc_no_err", 32'(m0_err), 32'd0);
        step(); drive_m0(1'b0, '0, '0, '0);
        look();
        chk("wr4000_err", 32'(m0_err), 32'd1);
        chk("mem0_untouched", mem[0], 32'hC0DE0000);

        // back-to-back reads across owners, then an out-of-range read
        step(); drive_m0(1'b1, 32'h20, '0, 4'b0000);
        step(); drive_m0(1'b0, '0, '0, '0); drive_m1(1'b1, 32'h3FFC, '0, 4'b0000);
        look();
        chk("b2b_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("b2b_m0_rdata", rdata, 32'hC0DEBEEF);
        step(); drive_m1(1'b1, 32'h4000, '0, 4'b0000);
        look();
        chk("b2b_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("b2b_m1_rdata", rdata, 32'h12345678);
        step(); drive_m1(1'b0, '0, '0, '0);
        look();
        chk("oor_rd_err", 32'(m1_err), 32'd1);
        chk("oor_rd_rdata", rdata, 32'd0);

        // both masters requesting continuously
        step(); step();
        drive_m0(1'b1, 32'h0, '0, 4'b0000);
        drive_m1(1'b1, 32'h4, '0, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            look();
            gseq.push_back(m1_gnt ? 1 : (m0_gnt ? 0 : 2));
        end
        step(); drive_m0(1'b0, '0, '0, '0); drive_m1(1'b0, '0, '0, '0);
        for (int i = 0; i < 12; i++) chk($sformatf("burst_order_%0d", i), 32'(gseq[i]), 32'(exp_order[i]));

        // reset in the return cycle of a DMA read
        step(); drive_m1(1'b1, 32'h8, '0, 4'b0000);
        look();
        chk("rst_rd_gnt", 32'(m1_gnt), 32'd1);
        step(); reset = 1'b0;
        drive_m0(1'b1, 32'h10, 32'h11111111, 4'b1111);
        drive_m1(1'b1, 32'h14, 32'h22222222, 4'b1111);
        look();
        chk("rst_drop_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_no_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst_no_write", 32'(mem_byteen), 32'd0);
        step(); reset = 1'b1;
        look();
        chk("post_rst_tie_m0", 32'(m0_gnt), 32'd1);
        chk("post_rst_tie_m1", 32'(m1_gnt), 32'd0);
        step(); drive_m0(1'b0, '0, '0, '0); drive_m1(1'b0, '0, '0, '0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
